// File: rtl/vga_sync_pkg.sv
// Timing constants and shared types for the 640x480@60 VGA sync generator.
// Every other design file imports this package.
package vga_pkg;

    localparam int ADDR_W    = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = 800;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = 525;

    typedef logic [ADDR_W-1:0] addr_t;

    // True when val lies in the half-open window [lo, lo+len).
    function automatic logic in_window(addr_t val, int lo, int len);
        return (int'(val) >= lo) && (int'(val) < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Video timing bundle: the sync generator drives it, the pixel/address stage consumes it.
interface vga_sync_if;
    import vga_pkg::*;

    addr_t addrH;
    addr_t addrV;
    logic  videoOn;
    logic  hsync;
    logic  vsync;
    logic  pixTick;
    logic  lineStart;
    logic  frameStart;

    modport master (
        output addrH, addrV, videoOn, hsync, vsync, pixTick, lineStart, frameStart
    );

    modport slave (
        input  addrH, addrV, videoOn, hsync, vsync, pixTick, lineStart, frameStart
    );

endinterface

// File: rtl/vga_sync_mod_counter.sv
// Modulo counter 0..TERMINAL with enable; exposes the next value so the
// parent can register decodes that line up with the count.
module mod_counter
    import vga_pkg::*;
#(
    parameter int TERMINAL = H_TOTAL - 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en_i,
    output addr_t count_o,
    output addr_t count_next_o,
    output logic  wrap_o
);

    localparam addr_t TERM = addr_t'(TERMINAL);

    addr_t count_q;
    addr_t count_d;

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == TERM) ? '0 : count_q + addr_t'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign wrap_o       = en_i && (count_q == TERM);

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: 25 MHz pixel strobe from a 50 MHz clock, pixel/line
// counters, registered sync/blanking decodes and line/frame start pulses.
module vga_sync
    import vga_pkg::*;
#(
    parameter int P_H_VISIBLE = H_VISIBLE,
    parameter int P_H_FP      = H_FP,
    parameter int P_H_SYNC    = H_SYNC,
    parameter int P_H_TOTAL   = H_TOTAL,
    parameter int P_V_VISIBLE = V_VISIBLE,
    parameter int P_V_FP      = V_FP,
    parameter int P_V_SYNC    = V_SYNC,
    parameter int P_V_TOTAL   = V_TOTAL
) (
    input  logic       clk,
    input  logic       rst_n,
    vga_sync_if.master vga
);

    logic  tick_q, tick_d;
    logic  video_on_q, video_on_d;
    logic  hsync_q, hsync_d;
    logic  vsync_q, vsync_d;
    logic  line_start_q, line_start_d;
    logic  frame_start_q, frame_start_d;

    addr_t h_count, h_next;
    addr_t v_count, v_next;
    logic  h_wrap, v_wrap;

    assign tick_d = ~tick_q;

    mod_counter #(.TERMINAL(P_H_TOTAL - 1)) u_h_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (tick_q),
        .count_o      (h_count),
        .count_next_o (h_next),
        .wrap_o       (h_wrap)
    );

    // h_wrap already includes the pixel strobe, so lines advance once per wrap.
    mod_counter #(.TERMINAL(P_V_TOTAL - 1)) u_v_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (h_wrap),
        .count_o      (v_count),
        .count_next_o (v_next),
        .wrap_o       (v_wrap)
    );

    // Decode from the next counts so the registered outputs align with addrH/addrV.
    always_comb begin
        video_on_d    = video_on_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (tick_q) begin
            video_on_d    = in_window(h_next, 0, P_H_VISIBLE) && in_window(v_next, 0, P_V_VISIBLE);
            hsync_d       = !in_window(h_next, P_H_VISIBLE + P_H_FP, P_H_SYNC);
            vsync_d       = !in_window(v_next, P_V_VISIBLE + P_V_FP, P_V_SYNC);
            line_start_d  = h_wrap;
            frame_start_d = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q        <= 1'b0;
            video_on_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.addrH      = h_count;
    assign vga.addrV      = v_count;
    assign vga.videoOn    = video_on_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.pixTick    = tick_q;
    assign vga.lineStart  = line_start_q;
    assign vga.frameStart = frame_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync: a full-timing instance plus a short-frame
// instance (10 lines, sync on lines 6-7) so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_sync;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    vga_sync_if vb ();
    vga_sync_if vs ();

    vga_sync dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vb)
    );

    vga_sync #(
        .P_V_VISIBLE (4),
        .P_V_FP      (2),
        .P_V_SYNC    (2),
        .P_V_TOTAL   (10)
    ) dut_short (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vs)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-instance vertical geometry: index 0 = full timing, 1 = short frame.
    function automatic int vmax(int d);
        return (d == 0) ? 524 : 9;
    endfunction
    function automatic int vvis(int d);
        return (d == 0) ? 480 : 4;
    endfunction
    function automatic int vss(int d);
        return (d == 0) ? 490 : 6;
    endfunction

    // Monitor state, cleared while rst_n is low.
    int   cyc, pt_bad, step_bad, bound_bad, dbl_bad;
    int   h[2], v[2], prev_h[2], prev_v[2];
    logic pt[2], ls[2], fs[2], hs[2], vsy[2], von[2];
    logic prev_pt[2], prev_ls[2], prev_fs[2], prev_hs[2], prev_vs[2];
    int   ls_cnt[2], first_ls[2], last_ls[2], per_bad[2], ls_since[2];
    int   fs_cnt[2], first_fs[2], last_fs[2], fs_gap[2], frame_ls_bad[2], last_frame_ls[2];
    int   hs_run[2], hs_pulses[2], hs_len_bad[2], hs_start_bad[2];
    int   vs_run[2], vs_pulses[2], vs_len_bad[2], vs_start_bad[2];
    int   line_von[2], lines_eval[2], line_bad[2], frame_von[2], last_frame_von[2];

    task automatic monitor_step();
        int exp_h, exp_v, exp_l;
        h[0] = int'(vb.addrH); v[0] = int'(vb.addrV); pt[0] = vb.pixTick; ls[0] = vb.lineStart;
        fs[0] = vb.frameStart; hs[0] = vb.hsync; vsy[0] = vb.vsync; von[0] = vb.videoOn;
        h[1] = int'(vs.addrH); v[1] = int'(vs.addrV); pt[1] = vs.pixTick; ls[1] = vs.lineStart;
        fs[1] = vs.frameStart; hs[1] = vs.hsync; vsy[1] = vs.vsync; von[1] = vs.videoOn;
        if (!rst_n) begin
            cyc = 0; pt_bad = 0; step_bad = 0; bound_bad = 0; dbl_bad = 0;
            for (int d = 0; d < 2; d++) begin
                prev_h[d] = 0; prev_v[d] = 0; prev_pt[d] = 0; prev_ls[d] = 0; prev_fs[d] = 0;
                prev_hs[d] = 1; prev_vs[d] = 1;
                ls_cnt[d] = 0; first_ls[d] = 0; last_ls[d] = 0; per_bad[d] = 0; ls_since[d] = 0;
                fs_cnt[d] = 0; first_fs[d] = 0; last_fs[d] = 0; fs_gap[d] = 0;
                frame_ls_bad[d] = 0; last_frame_ls[d] = 0;
                hs_run[d] = 0; hs_pulses[d] = 0; hs_len_bad[d] = 0; hs_start_bad[d] = 0;
                vs_run[d] = 0; vs_pulses[d] = 0; vs_len_bad[d] = 0; vs_start_bad[d] = 0;
                line_von[d] = 0; lines_eval[d] = 0; line_bad[d] = 0;
                frame_von[d] = 0; last_frame_von[d] = 0;
            end
            return;
        end
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (pt[d] == prev_pt[d]) pt_bad++;
            if ((ls[d] && prev_ls[d]) || (fs[d] && prev_fs[d])) dbl_bad++;
            if (h[d] > 799 || v[d] > vmax(d)) bound_bad++;
            // Counters may only move on the edge after a pixTick-high cycle.
            exp_h = prev_pt[d] ? ((prev_h[d] == 799) ? 0 : prev_h[d] + 1) : prev_h[d];
            exp_v = (prev_pt[d] && prev_h[d] == 799) ?
                    ((prev_v[d] == vmax(d)) ? 0 : prev_v[d] + 1) : prev_v[d];
            if (h[d] != exp_h || v[d] != exp_v) step_bad++;
            if (ls[d]) begin
                if (h[d] != 0) per_bad[d]++;
                if (ls_cnt[d] == 0) first_ls[d] = cyc;
                else if (cyc - last_ls[d] != 1600) per_bad[d]++;
                last_ls[d] = cyc; ls_cnt[d]++; ls_since[d]++;
            end
            if (fs[d]) begin
                if (!ls[d] || v[d] != 0 || ls_since[d] != vmax(d) + 1) frame_ls_bad[d]++;
                if (fs_cnt[d] == 0) first_fs[d] = cyc;
                else fs_gap[d] = cyc - last_fs[d];
                last_fs[d] = cyc; fs_cnt[d]++;
                last_frame_ls[d] = ls_since[d]; ls_since[d] = 0;
                last_frame_von[d] = frame_von[d]; frame_von[d] = 0;
            end
            if (v[d] != prev_v[d]) begin
                exp_l = (prev_v[d] < vvis(d)) ? ((lines_eval[d] == 0) ? 639 : 640) : 0;
                if (line_von[d] != exp_l) line_bad[d]++;
                lines_eval[d]++; line_von[d] = 0;
            end
            if (pt[d] && von[d]) begin
                line_von[d]++; frame_von[d]++;
            end
            if (!hs[d]) begin
                if (prev_hs[d]) begin
                    hs_run[d] = 0;
                    if (h[d] != 656) hs_start_bad[d]++;
                end
                hs_run[d]++;
            end else if (!prev_hs[d]) begin
                hs_pulses[d]++;
                if (hs_run[d] != 192) hs_len_bad[d]++;
            end
            if (!vsy[d]) begin
                if (prev_vs[d]) begin
                    vs_run[d] = 0;
                    if (v[d] != vss(d) || h[d] != 0) vs_start_bad[d]++;
                end
                vs_run[d]++;
            end else if (!prev_vs[d]) begin
                vs_pulses[d]++;
                if (vs_run[d] != 3200) vs_len_bad[d]++;
            end
            prev_h[d] = h[d]; prev_v[d] = v[d]; prev_pt[d] = pt[d]; prev_ls[d] = ls[d];
            prev_fs[d] = fs[d]; prev_hs[d] = hs[d]; prev_vs[d] = vsy[d];
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    initial begin
        int guard;

        // Reset hold: every output at its idle value.
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_addrH", vb.addrH, 0);
        check("rst_addrV", vb.addrV, 0);
        check("rst_videoOn", vb.videoOn, 0);
        check("rst_hsync", vb.hsync, 1);
        check("rst_vsync", vb.vsync, 1);
        check("rst_pixTick", vb.pixTick, 0);
        check("rst_lineStart", vb.lineStart, 0);
        check("rst_frameStart", vb.frameStart, 0);

        // Release between edges; pixTick rises after edge 1, first advance on edge 2.
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rel1_pixTick", vb.pixTick, 1);
        check("rel1_addrH", vb.addrH, 0);
        check("rel1_videoOn", vb.videoOn, 0);
        @(negedge clk);
        check("rel2_pixTick", vb.pixTick, 0);
        check("rel2_addrH", vb.addrH, 1);
        check("rel2_videoOn", vb.videoOn, 1);
        check("rel2_hsync", vb.hsync, 1);
        check("rel2_lineStart", vb.lineStart, 0);

        // Run into the short frame's last sync line (addrV=7, addrH=700).
        guard = 0;
        while (!(vs.addrV == 10'd7 && vs.addrH == 10'd700) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("phaseA_reached", guard < 20000, 1);
        check("line_first_start", first_ls[0], 1600);
        check("line_starts", ls_cnt[0], 7);
        check("line_period_errs", per_bad[0], 0);
        check("hsync_pulses", hs_pulses[0], 7);
        check("hsync_len_errs", hs_len_bad[0], 0);
        check("hsync_start_errs", hs_start_bad[0], 0);
        check("no_early_frameStart", fs_cnt[0] + fs_cnt[1], 0);
        check("pre_rst_vsync", vs.vsync, 0);
        check("pre_rst_hsync", vs.hsync, 0);

        // Asynchronous reset mid-vsync: outputs clear with no clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_vsync", vs.vsync, 1);
        check("mid_rst_hsync", vs.hsync, 1);
        check("mid_rst_addrH", vs.addrH, 0);
        check("mid_rst_addrV", vs.addrV, 0);
        check("mid_rst_pixTick", vs.pixTick, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Two full short frames after the second release.
        guard = 0;
        while (fs_cnt[1] < 2 && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("frame_count", fs_cnt[1], 2);
        check("frame_first_start", first_fs[1], 16000);
        check("frame_period", fs_gap[1], 16000);
        check("lines_per_frame", last_frame_ls[1], 10);
        check("frame_start_errs", frame_ls_bad[1], 0);
        check("vsync_pulses", vs_pulses[1], 2);
        check("vsync_len_errs", vs_len_bad[1], 0);
        check("vsync_start_errs", vs_start_bad[1], 0);
        check("frame_video_px", last_frame_von[1], 2560);
        check("short_lines_eval", lines_eval[1], 20);
        check("short_line_px_errs", line_bad[1], 0);
        check("full_lines_eval", lines_eval[0], 20);
        check("full_line_px_errs", line_bad[0], 0);
        check("full_no_frameStart", fs_cnt[0], 0);
        check("full_no_vsync", vs_pulses[0] + vs_run[0], 0);
        check("line_period_errs_b", per_bad[0] + per_bad[1], 0);
        check("hsync_errs_b", hs_len_bad[0] + hs_start_bad[0] + hs_len_bad[1] + hs_start_bad[1], 0);
        check("pixTick_toggle_errs", pt_bad, 0);
        check("counter_step_errs", step_bad, 0);
        check("counter_bound_errs", bound_bad, 0);
        check("double_pulse_errs", dbl_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 clk  input  1  50 MHz system clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 addrH  output  10  registered horizontal pixel counter, 0-799; consumed by the address lookup stage.
REQ-004 addrV  output  10  registered vertical line counter, 0-524.
REQ-005 videoOn  output  1  high when addrH<640 and addrV<480.
REQ-006 hsync  output  1  horizontal sync, active low.
REQ-007 vsync  output  1  vertical sync, active low.
REQ-008 pixTick  output  1  25 MHz pixel-enable strobe, one clk cycle wide.
REQ-009 lineStart  output  1  one-clk pulse when addrH wraps to 0.
REQ-010 frameStart  output  1  one-clk pulse when (addrH,addrV) wraps to (0,0).

Function
REQ-011 Internal divide-by-2 toggle SHALL generate pixTick high on every second clk cycle, exactly 1 clk wide.
REQ-012 Counters SHALL advance only on clk edges where pixTick is high; otherwise all outputs except pixTick, lineStart and frameStart SHALL hold.
REQ-013 Horizontal counter SHALL count 0..799, then wrap to 0: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-014 Vertical counter SHALL increment only on the pixTick edge where addrH wraps 799->0, count 0..524, then wrap to 0: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-015 hsync SHALL be 0 exactly while addrH is in 656-751, else 1; vsync SHALL be 0 exactly while addrV is in 490-491, else 1.
REQ-016 hsync, vsync and videoOn SHALL be registered, decoded from the next-count values on the advance edge, so they are cycle-aligned with addrH/addrV (zero relative latency).
REQ-017 lineStart SHALL be high only for the clk cycle immediately following the advance edge that set addrH to 0; it SHALL clear on the next clk edge.
REQ-018 frameStart SHALL be high only when lineStart is high and addrV became 0 on the same edge.
REQ-019 Counter widths SHALL be 10 bits; no count SHALL exceed its terminal value (799 / 524) in any cycle.

Reset
REQ-020 While rst_n=0: addrH=0, addrV=0, videoOn=0, hsync=1, vsync=1, pixTick=0, lineStart=0, frameStart=0, divider state=0.
REQ-021 Reset SHALL take effect immediately regardless of clk; assertion mid-line or mid-frame SHALL abandon the frame with no partial sync pulse remaining.
REQ-022 After release, the first pixTick SHALL occur on the second clk rising edge; the first advance SHALL give addrH=1, videoOn=1 (pixel 0 of the first post-reset frame is dark, by design).
REQ-023 No frameStart SHALL be emitted on reset release; the first frameStart SHALL follow the first 524->0 vertical wrap.

Structure
REQ-024 Package vga_pkg SHALL hold H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525; the RTL SHALL contain no literal timing numbers.
REQ-025 A sub-module mod_counter (parameterised terminal value, enable in, wrap pulse out) SHALL be instantiated twice, once horizontally and once vertically; everything else stays in vga_sync.

Verification
REQ-026 Reset hold 10 clk -> every output at its REQ-020 value; release -> pixTick high on 2nd edge, addrH=1 after 1st advance.
REQ-027 Run one line -> pixTick period 2 clk; addrH 0..799 then 0; line period 1600 clk; hsync low for exactly 192 clk, starting when addrH=656.
REQ-028 Run two full frames -> frame period 840000 clk; vsync low for exactly 3200 clk, starting when addrV=490; exactly one frameStart per frame; 525 lineStart pulses between frameStarts.
REQ-029 Count videoOn per line -> 640 pixTick-high cycles on lines 0-479, 0 on lines 480-524; 307200 per frame.
REQ-030 Assert rst_n at addrH=700, addrV=491 (inside vsync) -> vsync=1, hsync=1, counters 0 within the same cycle, no clk edge needed; after release the next frame matches REQ-028 timing.
REQ-031 Assertions throughout: addrH<=799, addrV<=524; pixTick, lineStart and frameStart never high for two consecutive clk cycles.
